rv32i_data_memory: RTL and testbench
====================================

RV32I_DATA_MEMORY -- requirements
Module: rv32i_data_memory

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, number of 32-bit words (power of two).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte address of word 0.
REQ-003 SHALL have a single clock; reset is asynchronous and active-high.
REQ-004 SHALL have port sys_clk  in  1  clock; all state updates on its rising edge.
REQ-005 SHALL have port sys_reset  in  1  async active-high reset.
REQ-006 SHALL have port memory_address  in  32  byte address from the CPU.
REQ-007 SHALL have port to_memory  in  32  store data; bytes taken from the low lanes.
REQ-008 SHALL have port memload_flag  in  1  load request.
REQ-009 SHALL have port memstore_flag  in  1  store request.
REQ-010 SHALL have port mem_funct3  in  3  RV32I funct3 of the load/store.
REQ-011 SHALL have port from_memory  out  32  load data, extended per funct3.
REQ-012 SHALL have port mem_ready  out  1  one-cycle completion strobe.
REQ-013 SHALL have port mem_fault  out  1  completion is an error; qualified by mem_ready.

Function
REQ-014 SHALL implement FSM IDLE -> ACCESS -> DONE -> IDLE, plus IDLE -> DONE on fault.
REQ-015 SHALL sample a request only in IDLE; the requester holds address, data, flags and funct3 stable until mem_ready.
REQ-016 SHALL treat memload_flag=1 and memstore_flag=1 together as a fault.
REQ-017 SHALL also fault on: undefined funct3 (load 011/110/111; store other than 000/001/010); misaligned access (half with addr[0]=1, word with addr[1:0]!=0); address outside BASE_ADDR..BASE_ADDR+4*DEPTH_WORDS-1.
REQ-018 SHALL, on a fault, perform no array access and go directly to DONE with mem_fault=1 and from_memory=0.
REQ-019 SHALL read the array into a registered word in ACCESS for a load; DONE drives the extended result: LB/LH sign-extend, LBU/LHU zero-extend, little-endian lane select by addr[1:0].
REQ-020 SHALL write only the byte lanes enabled by size and addr[1:0] at the edge leaving ACCESS; unselected bytes are unchanged.
REQ-021 SHALL assert mem_ready in DONE only, for exactly one cycle; load latency is 2 cycles and fault latency is 1 cycle from request sampling in IDLE.
REQ-022 SHALL hold from_memory=0 whenever mem_ready=0.
REQ-023 SHALL always pass DONE to IDLE; a request still asserted is re-sampled as new on the following cycle.

Reset
REQ-024 SHALL, on sys_reset, drive state=IDLE, mem_ready=0, mem_fault=0, from_memory=0 immediately, without waiting for a clock edge.
REQ-025 SHALL leave array contents undefined and unaffected by reset.
REQ-026 SHALL abort a store whose reset lands in ACCESS: no array write occurs.

Configuration
REQ-027 SHALL provide macro RV32I_DMEM_FAULT_EN to enable fault detection.
REQ-028 With RV32I_DMEM_FAULT_EN defined: REQ-016..018 apply as written.
REQ-029 Without RV32I_DMEM_FAULT_EN:
- mem_fault is tied 0.
- Misaligned addresses are force-aligned by clearing the low bits.
- Out-of-range addresses wrap modulo DEPTH_WORDS.
- Undefined funct3 is treated as word access.
- A simultaneous load and store executes as a load.

Structure
REQ-030 SHALL place funct3 encodings (LB/LH/LW/LBU/LHU/SB/SH/SW) and the FSM state enum in shared package rv32i_pkg.
REQ-031 SHALL implement the storage array as sub-module rv32i_dmem_array (sync read, byte-enable write); lane extract/extend logic stays in the parent.

Verification
REQ-032 SHALL cover: SW 0xDEADBEEF @0x10, then LW @0x10 -> mem_ready at cycle 2, from_memory=0xDEADBEEF, fault=0.
REQ-033 SHALL cover: SB 0x80 @0x13, then LB @0x13 -> 0xFFFFFF80; LBU -> 0x00000080; LW @0x10 -> 0x80ADBEEF.
REQ-034 SHALL cover: LH @0x11 with FAULT_EN -> mem_ready and mem_fault at cycle 1, from_memory=0; without FAULT_EN -> LH @0x10 result.
REQ-035 SHALL cover: load and store flags together @0x20 with FAULT_EN -> fault, array @0x20 unchanged.
REQ-036 SHALL cover: SW 0x12345678 @0x30 with sys_reset pulsed in ACCESS -> outputs 0 at once, LW @0x30 returns the prior value.
REQ-037 SHALL cover: address BASE_ADDR+4*DEPTH_WORDS with FAULT_EN -> fault; without FAULT_EN -> aliases word 0.

Source files
------------

// File: rtl/rv32i_pkg.sv
// -----------------------------------------------------------------------------
// rv32i_pkg
// Shared definitions for the RV32I data memory slice:
//   - RV32I load/store funct3 encodings (LB/LH/LW/LBU/LHU, SB/SH/SW)
//   - FSM state enum used by rv32i_data_memory
//   - access size enum and small lane helper functions
// No ports (package).
// -----------------------------------------------------------------------------
package rv32i_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } dmem_state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } access_size_t;

    // Undefined encodings fall back to a full word access.
    function automatic access_size_t size_of(input logic [2:0] funct3, input logic valid);
        if (!valid) return SZ_WORD;
        case (funct3[1:0])
            2'b00:   return SZ_BYTE;
            2'b01:   return SZ_HALF;
            default: return SZ_WORD;
        endcase
    endfunction

    // Clears the low address bits that a given size cannot use.
    function automatic logic [1:0] align_lane(input access_size_t size, input logic [1:0] lane);
        case (size)
            SZ_BYTE: return lane;
            SZ_HALF: return {lane[1], 1'b0};
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [3:0] lane_enables(input access_size_t size, input logic [1:0] lane);
        case (size)
            SZ_BYTE: return 4'b0001 << lane;
            SZ_HALF: return lane[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    // Store data is replicated across lanes so the byte enables pick the target lane.
    function automatic logic [31:0] lane_replicate(input access_size_t size, input logic [31:0] data);
        case (size)
            SZ_BYTE: return {4{data[7:0]}};
            SZ_HALF: return {2{data[15:0]}};
            default: return data;
        endcase
    endfunction

endpackage

// File: rtl/rv32i_dmem_array.sv
// -----------------------------------------------------------------------------
// rv32i_dmem_array
// Word-organised storage with a synchronous read port and a byte-enable write
// port. Contents have no reset.
// Ports:
//   clk         in   1   clock
//   read_en     in   1   capture mem[addr] into read_data on the rising edge
//   write_en    in   1   write enabled byte lanes on the rising edge
//   addr        in   AW  word index
//   byte_en     in   4   lane enables for the write
//   write_data  in   32  write data (lane-aligned)
//   read_data   out  32  registered read word
// -----------------------------------------------------------------------------
module rv32i_dmem_array #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = 10
) (
    input  logic          clk,
    input  logic          read_en,
    input  logic          write_en,
    input  logic [AW-1:0] addr,
    input  logic [3:0]    byte_en,
    input  logic [31:0]   write_data,
    output logic [31:0]   read_data
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (write_en) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem[addr][8*i +: 8] <= write_data[8*i +: 8];
                end
            end
        end
        if (read_en) begin
            read_data <= mem[addr];
        end
    end

endmodule

// File: rtl/rv32i_data_memory.sv
// -----------------------------------------------------------------------------
// rv32i_data_memory
// RV32I data memory with a three-state handshake (IDLE -> ACCESS -> DONE).
// Loads complete two cycles after being sampled, faults one cycle after.
// Optional macro RV32I_DMEM_FAULT_EN enables fault detection (both flags,
// undefined funct3, misalignment, out-of-range). Without it, accesses are
// force-aligned, wrap modulo DEPTH_WORDS, undefined funct3 acts as a word
// access and load wins over store.
// Ports:
//   sys_clk         in   1   clock
//   sys_reset       in   1   asynchronous active-high reset
//   memory_address  in   32  byte address
//   to_memory       in   32  store data (low lanes)
//   memload_flag    in   1   load request
//   memstore_flag   in   1   store request
//   mem_funct3      in   3   RV32I funct3
//   from_memory     out  32  extended load data, 0 unless mem_ready
//   mem_ready       out  1   one-cycle completion strobe
//   mem_fault       out  1   completion is an error (qualified by mem_ready)
// -----------------------------------------------------------------------------
module rv32i_data_memory
    import rv32i_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        sys_clk,
    input  logic        sys_reset,
    input  logic [31:0] memory_address,
    input  logic [31:0] to_memory,
    input  logic        memload_flag,
    input  logic        memstore_flag,
    input  logic [2:0]  mem_funct3,
    output logic [31:0] from_memory,
    output logic        mem_ready,
    output logic        mem_fault
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    dmem_state_t  state;
    dmem_state_t  next_state;

    logic         req;
    logic         req_is_load;
    logic         f3_valid;
    logic         req_fault;
    logic [31:0]  offset;
    access_size_t req_size;
    logic [1:0]   req_lane;
    logic [AW-1:0] req_idx;

    logic         fault_q;
    logic         load_q;
    logic         unsigned_q;
    access_size_t size_q;
    logic [1:0]   lane_q;
    logic [AW-1:0] idx_q;
    logic [31:0]  wdata_q;
    logic [3:0]   be_q;
    logic [31:0]  rdata;

    logic [7:0]   byte_val;
    logic [15:0]  half_val;
    logic [31:0]  ext_val;

    // Request decode. Validity is judged against the load or store funct3
    // table; a request with both flags is decoded as a load.
    always_comb begin
        req         = memload_flag | memstore_flag;
        req_is_load = memload_flag;
        offset      = memory_address - BASE_ADDR;
        if (req_is_load) begin
            f3_valid = mem_funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
        end else begin
            f3_valid = mem_funct3 inside {F3_SB, F3_SH, F3_SW};
        end
        req_size = size_of(mem_funct3, f3_valid);
        req_lane = align_lane(req_size, offset[1:0]);
        // Truncating the word offset gives the modulo-DEPTH wrap for free.
        req_idx  = AW'(offset >> 2);
`ifdef RV32I_DMEM_FAULT_EN
        req_fault = (memload_flag & memstore_flag)
                  | ~f3_valid
                  | ((req_size == SZ_HALF) & offset[0])
                  | ((req_size == SZ_WORD) & (offset[1:0] != 2'b00))
                  | (offset >= 32'(4 * DEPTH_WORDS));
`else
        req_fault = 1'b0;
`endif
    end

    always_ff @(posedge sys_clk or posedge sys_reset) begin
        if (sys_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Faults skip ACCESS so the array is never touched for them.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    next_state = req_fault ? ST_DONE : ST_ACCESS;
                end
            end
            ST_ACCESS: next_state = ST_DONE;
            ST_DONE:   next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    // Capture the decoded request when it is sampled in IDLE.
    always_ff @(posedge sys_clk or posedge sys_reset) begin
        if (sys_reset) begin
            fault_q    <= 1'b0;
            load_q     <= 1'b0;
            unsigned_q <= 1'b0;
            size_q     <= SZ_WORD;
            lane_q     <= 2'b00;
            idx_q      <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
        end else if (state == ST_IDLE && req) begin
            fault_q    <= req_fault;
            load_q     <= req_is_load;
            unsigned_q <= mem_funct3[2] & f3_valid;
            size_q     <= req_size;
            lane_q     <= req_lane;
            idx_q      <= req_idx;
            wdata_q    <= lane_replicate(req_size, to_memory);
            be_q       <= lane_enables(req_size, req_lane);
        end
    end

    // Enables depend on the live state, so a reset during ACCESS returns the
    // state to IDLE before the next edge and the pending write is dropped.
    rv32i_dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clk        (sys_clk),
        .read_en    ((state == ST_ACCESS) && load_q),
        .write_en   ((state == ST_ACCESS) && !load_q),
        .addr       (idx_q),
        .byte_en    (be_q),
        .write_data (wdata_q),
        .read_data  (rdata)
    );

    // Little-endian lane select and sign/zero extension of the read word.
    always_comb begin
        byte_val = rdata[{lane_q, 3'b000} +: 8];
        half_val = lane_q[1] ? rdata[31:16] : rdata[15:0];
        case (size_q)
            SZ_BYTE: ext_val = unsigned_q ? {24'h0, byte_val} : {{24{byte_val[7]}}, byte_val};
            SZ_HALF: ext_val = unsigned_q ? {16'h0, half_val} : {{16{half_val[15]}}, half_val};
            default: ext_val = rdata;
        endcase
        from_memory = ((state == ST_DONE) && load_q && !fault_q) ? ext_val : 32'h0;
    end

    assign mem_ready = (state == ST_DONE);

`ifdef RV32I_DMEM_FAULT_EN
    assign mem_fault = (state == ST_DONE) & fault_q;
`else
    assign mem_fault = 1'b0;
`endif

endmodule

// File: tb/tb_rv32i_data_memory.sv
// -----------------------------------------------------------------------------
// tb_rv32i_data_memory
// Directed self-checking bench for rv32i_data_memory. Expected completions are
// queued as each request is driven and popped when mem_ready is seen.
// Expectations follow RV32I_DMEM_FAULT_EN when it is defined.
// -----------------------------------------------------------------------------
module tb_rv32i_data_memory;
    import rv32i_pkg::*;

`ifdef RV32I_DMEM_FAULT_EN
    localparam bit FAULT_EN = 1'b1;
`else
    localparam bit FAULT_EN = 1'b0;
`endif

    logic        sys_clk;
    logic        sys_reset;
    logic [31:0] memory_address;
    logic [31:0] to_memory;
    logic        memload_flag;
    logic        memstore_flag;
    logic [2:0]  mem_funct3;
    logic [31:0] from_memory;
    logic        mem_ready;
    logic        mem_fault;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [31:0] data;
        logic        fault;
        int          latency;
    } expect_t;

    expect_t scoreboard[$];

    rv32i_data_memory #(
        .DEPTH_WORDS (1024),
        .BASE_ADDR   (32'h0000_0000)
    ) dut (
        .sys_clk        (sys_clk),
        .sys_reset      (sys_reset),
        .memory_address (memory_address),
        .to_memory      (to_memory),
        .memload_flag   (memload_flag),
        .memstore_flag  (memstore_flag),
        .mem_funct3     (mem_funct3),
        .from_memory    (from_memory),
        .mem_ready      (mem_ready),
        .mem_fault      (mem_fault)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Drive a request on the falling edge and queue its expected completion.
    task automatic applyStimulus(input logic ld, input logic st, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] data,
                                 input logic [31:0] exp_data, input logic exp_fault,
                                 input int exp_latency);
        expect_t e;
        @(negedge sys_clk);
        memload_flag   = ld;
        memstore_flag  = st;
        mem_funct3     = f3;
        memory_address = addr;
        to_memory      = data;
        e.data    = exp_data;
        e.fault   = exp_fault;
        e.latency = exp_latency;
        scoreboard.push_back(e);
    endtask

    // Wait (bounded) for mem_ready, compare against the queue head, then
    // confirm the strobe lasts a single cycle.
    task automatic checkOutput(input string tag);
        expect_t e;
        int n;
        bit seen;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 8) begin
            @(posedge sys_clk);
            #1;
            n++;
            if (mem_ready) seen = 1'b1;
            else checkValue({tag, " quiet_data"}, from_memory, 32'h0);
        end
        memload_flag  = 1'b0;
        memstore_flag = 1'b0;
        e = scoreboard.pop_front();
        checkValue({tag, " ready"},   {31'b0, mem_ready}, 32'd1);
        checkValue({tag, " data"},    from_memory, e.data);
        checkValue({tag, " fault"},   {31'b0, mem_fault}, {31'b0, e.fault});
        checkValue({tag, " latency"}, 32'(n), 32'(e.latency));
        @(posedge sys_clk);
        #1;
        checkValue({tag, " one_cycle"}, {31'b0, mem_ready}, 32'd0);
    endtask

    task automatic doAccess(input string tag, input logic ld, input logic st, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] data,
                            input logic [31:0] exp_data, input logic exp_fault, input int exp_latency);
        applyStimulus(ld, st, f3, addr, data, exp_data, exp_fault, exp_latency);
        checkOutput(tag);
    endtask

    initial begin
        sys_reset      = 1'b1;
        memload_flag   = 1'b0;
        memstore_flag  = 1'b0;
        mem_funct3     = 3'b000;
        memory_address = 32'h0;
        to_memory      = 32'h0;
        #12;
        checkValue("reset ready", {31'b0, mem_ready}, 32'd0);
        checkValue("reset fault", {31'b0, mem_fault}, 32'd0);
        checkValue("reset data",  from_memory, 32'h0);
        @(negedge sys_clk);
        sys_reset = 1'b0;

        doAccess("sw_10",  1'b0, 1'b1, F3_SW,  32'h10, 32'hDEAD_BEEF, 32'h0,         1'b0, 2);
        doAccess("lw_10",  1'b1, 1'b0, F3_LW,  32'h10, 32'h0,         32'hDEAD_BEEF, 1'b0, 2);
        doAccess("sb_13",  1'b0, 1'b1, F3_SB,  32'h13, 32'hAAAA_AA80, 32'h0,         1'b0, 2);
        doAccess("lb_13",  1'b1, 1'b0, F3_LB,  32'h13, 32'h0,         32'hFFFF_FF80, 1'b0, 2);
        doAccess("lbu_13", 1'b1, 1'b0, F3_LBU, 32'h13, 32'h0,         32'h0000_0080, 1'b0, 2);
        doAccess("lw_10b", 1'b1, 1'b0, F3_LW,  32'h10, 32'h0,         32'h80AD_BEEF, 1'b0, 2);
        doAccess("lhu_12", 1'b1, 1'b0, F3_LHU, 32'h12, 32'h0,         32'h0000_80AD, 1'b0, 2);
        doAccess("lh_12",  1'b1, 1'b0, F3_LH,  32'h12, 32'h0,         32'hFFFF_80AD, 1'b0, 2);

        doAccess("lh_11_misaligned", 1'b1, 1'b0, F3_LH, 32'h11, 32'h0,
                 FAULT_EN ? 32'h0 : 32'hFFFF_BEEF, FAULT_EN, FAULT_EN ? 1 : 2);

        doAccess("sw_20", 1'b0, 1'b1, F3_SW, 32'h20, 32'h1111_2222, 32'h0, 1'b0, 2);
        doAccess("both_flags_20", 1'b1, 1'b1, F3_SW, 32'h20, 32'h9999_9999,
                 FAULT_EN ? 32'h0 : 32'h1111_2222, FAULT_EN, FAULT_EN ? 1 : 2);
        doAccess("lw_20", 1'b1, 1'b0, F3_LW, 32'h20, 32'h0, 32'h1111_2222, 1'b0, 2);

        doAccess("load_f3_110", 1'b1, 1'b0, 3'b110, 32'h10, 32'h0,
                 FAULT_EN ? 32'h0 : 32'h80AD_BEEF, FAULT_EN, FAULT_EN ? 1 : 2);

        doAccess("sw_40", 1'b0, 1'b1, F3_SW, 32'h40, 32'h5566_7788, 32'h0, 1'b0, 2);
        doAccess("store_f3_011", 1'b0, 1'b1, 3'b011, 32'h40, 32'hA1B2_C3D4,
                 32'h0, FAULT_EN, FAULT_EN ? 1 : 2);
        doAccess("lw_40", 1'b1, 1'b0, F3_LW, 32'h40, 32'h0,
                 FAULT_EN ? 32'h5566_7788 : 32'hA1B2_C3D4, 1'b0, 2);

        doAccess("sw_00", 1'b0, 1'b1, F3_SW, 32'h00, 32'h0BAD_F00D, 32'h0, 1'b0, 2);
        doAccess("lw_out_of_range", 1'b1, 1'b0, F3_LW, 32'h1000, 32'h0,
                 FAULT_EN ? 32'h0 : 32'h0BAD_F00D, FAULT_EN, FAULT_EN ? 1 : 2);

        // Store aborted by a reset pulse while in ACCESS.
        doAccess("sw_30", 1'b0, 1'b1, F3_SW, 32'h30, 32'hCAFE_F00D, 32'h0, 1'b0, 2);
        @(negedge sys_clk);
        memstore_flag  = 1'b1;
        mem_funct3     = F3_SW;
        memory_address = 32'h30;
        to_memory      = 32'h1234_5678;
        @(posedge sys_clk);
        #1;
        sys_reset = 1'b1;
        #1;
        checkValue("abort ready", {31'b0, mem_ready}, 32'd0);
        checkValue("abort fault", {31'b0, mem_fault}, 32'd0);
        checkValue("abort data",  from_memory, 32'h0);
        memstore_flag = 1'b0;
        @(posedge sys_clk);
        #1;
        sys_reset = 1'b0;
        doAccess("lw_30_after_abort", 1'b1, 1'b0, F3_LW, 32'h30, 32'h0, 32'hCAFE_F00D, 1'b0, 2);

        // Reset landing in DONE must clear the outputs without a clock edge.
        @(negedge sys_clk);
        memload_flag   = 1'b1;
        mem_funct3     = F3_LW;
        memory_address = 32'h10;
        @(posedge sys_clk);
        #1;
        @(posedge sys_clk);
        #1;
        checkValue("done_reset pre_ready", {31'b0, mem_ready}, 32'd1);
        checkValue("done_reset pre_data",  from_memory, 32'h80AD_BEEF);
        memload_flag = 1'b0;
        #2;
        sys_reset = 1'b1;
        #1;
        checkValue("done_reset ready", {31'b0, mem_ready}, 32'd0);
        checkValue("done_reset data",  from_memory, 32'h0);
        @(negedge sys_clk);
        sys_reset = 1'b0;

        doAccess("lw_10_final", 1'b1, 1'b0, F3_LW, 32'h10, 32'h0, 32'h80AD_BEEF, 1'b0, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
